pmc_dump_ctrl: RTL and testbench
================================

# pmc_dump_ctrl

Control and readout sequencer for the processor's performance-monitoring counters (stall, arithmetic, memory-access and instruction-cycle counters). It accepts START/STOP/CLEAR/DUMP commands from the debug/host side over a valid/ready handshake. It drives the run-gate and clear pulse seen by the counter bank. On DUMP it snapshots every counter in one cycle and streams the frozen values out one word per handshake, so the host reads a coherent set while the counters keep running.

## Interface
- NUM_CNT, default 4: number of counters in the bank; must be ≥ 2.
- CNT_W, default 32: width of each counter and of out_data.
- IDX_W, default $clog2(NUM_CNT): width of out_idx.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 CLEAR, 01 START, 10 STOP, 11 DUMP.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cnt_in  in  NUM_CNT*CNT_W  live counter values; counter k is in bits [k*CNT_W +: CNT_W].
- cnt_run  out  1  level gate ANDed into every counter enable.
- cnt_clear  out  1  one-cycle synchronous clear pulse to the counter bank.
- out_valid  out  1  out_data/out_idx/out_last are valid.
- out_ready  in  1  consumer accepts the current word.
- out_data  out  CNT_W  snapshot value of counter out_idx.
- out_idx  out  IDX_W  index of the word being presented.
- out_last  out  1  high with the word for counter NUM_CNT-1.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, STREAM.
- A command is accepted on any rising edge where cmd_valid && cmd_ready.
- Command effects in IDLE:
  - START: set cnt_run to 1.
  - STOP: set cnt_run to 0.
  - CLEAR: drive cnt_clear high for exactly the next cycle. cnt_run is unchanged.
  - DUMP: copy all NUM_CNT words of cnt_in into the snapshot registers, set idx to 0 and go to STREAM.
- STREAM behaviour:
  - out_valid = 1, out_data = snap[idx], out_idx = idx, out_last = (idx == NUM_CNT-1).
  - On out_valid && out_ready: if out_last, go to IDLE; otherwise increment idx.
- cmd_ready is 0 in STREAM, so commands offered during a dump stall until the dump ends. They are not dropped.
- cnt_run keeps its value through a DUMP. The live counters keep counting and the snapshot does not change.
- Reset values of all outputs: cmd_ready 1, cnt_run 0, cnt_clear 0, out_valid 0, out_data 0, out_idx 0, out_last 0, busy 0.
- Reset also sets the state to IDLE and all snapshot registers to 0.
- Reset asserted mid-stream aborts the dump immediately and asynchronously. No further words are emitted, and no autoclear pulse is issued even if configured.

## Timing
- START/STOP: cnt_run changes at the accepting edge and is visible in the following cycle.
- CLEAR: cnt_clear is high during the single cycle after the accepting edge, then low.
- Back-to-back CLEARs produce separate one-cycle pulses. A command accepted in the cycle where cnt_clear is high is legal.
- DUMP snapshot: each word equals the cnt_in value present before the accepting edge. An increment landing on that same edge is not captured.
- First word: out_valid rises in the cycle after DUMP acceptance.
- Throughput: with out_ready held high, one word per cycle, so NUM_CNT cycles in STREAM.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last are held stable.
- End of dump: cmd_ready returns in the cycle after the out_last handshake.

## Configuration
- PMC_DUMP_AUTOCLEAR_EN defined (read-and-clear mode): when the out_last word handshakes, cnt_clear is asserted for the cycle after that edge. This is the same cycle in which cmd_ready returns.
- PMC_DUMP_AUTOCLEAR_EN undefined: a dump never touches the counters. The only way to clear is an explicit CLEAR command.

## Test plan
- Reset check: assert reset mid-cycle → all outputs take their reset values immediately; after release cmd_ready=1 and cnt_run=0.
- Run gating: START → cnt_run=1 from the next cycle; STOP 10 cycles later → cnt_run=0 from the cycle after that STOP.
- DUMP, no backpressure: cnt_in = {40,30,20,10} (counter 3 down to counter 0), out_ready=1 → output sequence (idx,data) = (0,10),(1,20),(2,30),(3,40) on 4 consecutive cycles; out_last only on idx 3; cmd_ready=1 on the 5th cycle after acceptance.
- Backpressure and freeze: during a dump, hold out_ready=0 for 3 cycles on idx 1 while cnt_in keeps incrementing → out_data stays at the snapshot value (20), then the stream resumes in order.
- Clear and stalled command: CLEAR → exactly one cycle of cnt_clear=1; a STOP offered in mid-DUMP is accepted only in the cycle after the last handshake.
- Autoclear and abort: with PMC_DUMP_AUTOCLEAR_EN, cnt_clear=1 in the cycle after the idx 3 handshake. With reset asserted during idx 2, no cnt_clear pulse and out_valid=0.

Source files
------------

// File: rtl/pmc_dump_ctrl.sv
// Performance-counter control and snapshot readout sequencer.
// Optional read-and-clear mode: define PMC_DUMP_AUTOCLEAR_EN.
module pmc_dump_ctrl #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = $clog2(NUM_CNT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    output logic                     cmd_ready,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    output logic                     cnt_run,
    output logic                     cnt_clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
);

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] snap [NUM_CNT];

    // Outputs decode straight from registers so an async reset clears them at once.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == STREAM);
    assign out_idx   = idx;
    assign out_data  = snap[idx];
    assign out_last  = (state == STREAM) && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt_run   <= 1'b0;
            cnt_clear <= 1'b0;
            for (int k = 0; k < NUM_CNT; k++) begin
                snap[k] <= '0;
            end
        end else begin
            cnt_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_CLEAR: cnt_clear <= 1'b1;
                            OP_START: cnt_run   <= 1'b1;
                            OP_STOP:  cnt_run   <= 1'b0;
                            OP_DUMP: begin
                                // Freeze the whole bank on one edge for a coherent readout.
                                for (int k = 0; k < NUM_CNT; k++) begin
                                    snap[k] <= cnt_in[k*CNT_W +: CNT_W];
                                end
                                idx   <= '0;
                                state <= STREAM;
                            end
                            default: ;
                        endcase
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
`ifdef PMC_DUMP_AUTOCLEAR_EN
                            cnt_clear <= 1'b1;
`else
                            cnt_clear <= 1'b0;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmc_dump_ctrl.sv
// Directed self-checking bench for pmc_dump_ctrl (NUM_CNT=4, CNT_W=32).
module tb_pmc_dump_ctrl;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 32;
    localparam int IDX_W   = 2;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

`ifdef PMC_DUMP_AUTOCLEAR_EN
    localparam logic AUTO_CLR = 1'b1;
`else
    localparam logic AUTO_CLR = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     cmd_valid;
    logic [1:0]               cmd_op;
    logic                     cmd_ready;
    logic [NUM_CNT*CNT_W-1:0] cnt_in;
    logic                     cnt_run;
    logic                     cnt_clear;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    pmc_dump_ctrl #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .cnt_in(cnt_in), .cnt_run(cnt_run),
        .cnt_clear(cnt_clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge, where inputs are driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_counters();
        for (int k = 0; k < NUM_CNT; k++) begin
            cnt_in[k*CNT_W +: CNT_W] = cnt_in[k*CNT_W +: CNT_W] + 32'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_CLEAR; out_ready = 1'b0; cnt_in = '0;
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (cnt_run !== 1'b0) begin errors++; $display("[TB] FAIL rst_cnt_run: got %b expected 0", cnt_run); end
        // Put the block in a non-reset state, then reset mid-cycle with no edge.
        cmd_valid = 1'b1; cmd_op = OP_START;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cnt_run !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_run: got %b expected 1", cnt_run); end
        #2 reset = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (cnt_run !== 1'b0) begin errors++; $display("[TB] FAIL async_cnt_run: got %b expected 0", cnt_run); end
        checks++; if (cnt_clear !== 1'b0) begin errors++; $display("[TB] FAIL async_cnt_clear: got %b expected 0", cnt_clear); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL async_out_data: got %0d expected 0", out_data); end
        checks++; if (out_idx !== 2'd0) begin errors++; $display("[TB] FAIL async_out_idx: got %0d expected 0", out_idx); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL async_out_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %b expected 0", busy); end
        tick();
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_run_gating();
        cmd_valid = 1'b1; cmd_op = OP_START;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cnt_run !== 1'b1) begin errors++; $display("[TB] FAIL start_run: got %b expected 1", cnt_run); end
        repeat (9) tick();
        checks++; if (cnt_run !== 1'b1) begin errors++; $display("[TB] FAIL run_hold: got %b expected 1", cnt_run); end
        cmd_valid = 1'b1; cmd_op = OP_STOP;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cnt_run !== 1'b0) begin errors++; $display("[TB] FAIL stop_run: got %b expected 0", cnt_run); end
    endtask

    task automatic test_dump();
        cmd_valid = 1'b1; cmd_op = OP_START;
        tick();
        cnt_in = {32'd40, 32'd30, 32'd20, 32'd10};
        out_ready = 1'b1;
        cmd_op = OP_DUMP;
        tick();
        cmd_valid = 1'b0;
        // Counters advance after the accepting edge; the snapshot must not follow.
        bump_counters();
        for (int i = 0; i < NUM_CNT; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dump_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_idx !== IDX_W'(i)) begin errors++; $display("[TB] FAIL dump_idx[%0d]: got %0d expected %0d", i, out_idx, i); end
            checks++; if (out_data !== 32'(10 * (i + 1))) begin errors++; $display("[TB] FAIL dump_data[%0d]: got %0d expected %0d", i, out_data, 10 * (i + 1)); end
            checks++; if (out_last !== (i == NUM_CNT - 1)) begin errors++; $display("[TB] FAIL dump_last[%0d]: got %b expected %b", i, out_last, (i == NUM_CNT - 1)); end
            checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL dump_busy[%0d]: got ready=%b busy=%b expected ready=0 busy=1", i, cmd_ready, busy); end
            tick();
            bump_counters();
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL dump_end_ready: got %b expected 1", cmd_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL dump_end_idle: got valid=%b busy=%b expected 0 0", out_valid, busy); end
        checks++; if (cnt_run !== 1'b1) begin errors++; $display("[TB] FAIL dump_run_kept: got %b expected 1", cnt_run); end
        checks++; if (cnt_clear !== AUTO_CLR) begin errors++; $display("[TB] FAIL dump_autoclear: got %b expected %b", cnt_clear, AUTO_CLR); end
        tick();
        checks++; if (cnt_clear !== 1'b0) begin errors++; $display("[TB] FAIL dump_clear_drop: got %b expected 0", cnt_clear); end
    endtask

    task automatic test_backpressure();
        cnt_in = {32'd40, 32'd30, 32'd20, 32'd10};
        out_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_DUMP;
        tick();
        cmd_valid = 1'b0;
        checks++; if (out_idx !== 2'd0 || out_data !== 32'd10) begin errors++; $display("[TB] FAIL bp_word0: got idx=%0d data=%0d expected 0 10", out_idx, out_data); end
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bump_counters();
            tick();
            checks++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 32'd20 || out_last !== 1'b0) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b idx=%0d data=%0d last=%b expected 1 1 20 0", c, out_valid, out_idx, out_data, out_last);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_idx !== 2'd2 || out_data !== 32'd30) begin errors++; $display("[TB] FAIL bp_word2: got idx=%0d data=%0d expected 2 30", out_idx, out_data); end
        tick();
        checks++; if (out_idx !== 2'd3 || out_data !== 32'd40 || out_last !== 1'b1) begin errors++; $display("[TB] FAIL bp_word3: got idx=%0d data=%0d last=%b expected 3 40 1", out_idx, out_data, out_last); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_end: got ready=%b valid=%b expected 1 0", cmd_ready, out_valid); end
        tick();
    endtask

    task automatic test_clear_stalled();
        logic run_before;
        run_before = cnt_run;
        checks++; if (cnt_clear !== 1'b0) begin errors++; $display("[TB] FAIL clr_idle: got %b expected 0", cnt_clear); end
        cmd_valid = 1'b1; cmd_op = OP_CLEAR;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cnt_clear !== 1'b1) begin errors++; $display("[TB] FAIL clr_pulse: got %b expected 1", cnt_clear); end
        checks++; if (cnt_run !== run_before) begin errors++; $display("[TB] FAIL clr_run_kept: got %b expected %b", cnt_run, run_before); end
        tick();
        checks++; if (cnt_clear !== 1'b0) begin errors++; $display("[TB] FAIL clr_single: got %b expected 0", cnt_clear); end
        // Second CLEAR accepted in the cycle where the first pulse is high.
        cmd_valid = 1'b1;
        tick();
        checks++; if (cnt_clear !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got %b expected 1", cnt_clear); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (cnt_clear !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got %b expected 1", cnt_clear); end
        tick();
        checks++; if (cnt_clear !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %b expected 0", cnt_clear); end
        cmd_valid = 1'b1; cmd_op = OP_START;
        tick();
        cnt_in = {32'd4, 32'd3, 32'd2, 32'd1};
        out_ready = 1'b1;
        cmd_op = OP_DUMP;
        tick();
        cmd_op = OP_STOP;
        for (int i = 0; i < NUM_CNT; i++) begin
            checks++; if (cmd_ready !== 1'b0 || cnt_run !== 1'b1 || out_data !== 32'(i + 1)) begin
                errors++; $display("[TB] FAIL stall_word[%0d]: got ready=%b run=%b data=%0d expected 0 1 %0d", i, cmd_ready, cnt_run, out_data, i + 1);
            end
            tick();
        end
        checks++; if (cmd_ready !== 1'b1 || cnt_run !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got ready=%b run=%b expected 1 1", cmd_ready, cnt_run); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (cnt_run !== 1'b0) begin errors++; $display("[TB] FAIL stall_stop_taken: got %b expected 0", cnt_run); end
        tick();
    endtask

    task automatic test_abort();
        cnt_in = {32'd40, 32'd30, 32'd20, 32'd10};
        out_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_START;
        tick();
        cmd_op = OP_DUMP;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        checks++; if (out_idx !== 2'd2 || out_data !== 32'd30) begin errors++; $display("[TB] FAIL abort_at2: got idx=%0d data=%0d expected 2 30", out_idx, out_data); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle: got valid=%b busy=%b ready=%b expected 0 0 1", out_valid, busy, cmd_ready); end
        checks++; if (out_data !== 32'd0 || out_idx !== 2'd0 || cnt_run !== 1'b0) begin errors++; $display("[TB] FAIL abort_regs: got data=%0d idx=%0d run=%b expected 0 0 0", out_data, out_idx, cnt_run); end
        tick(); tick();
        #2 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (cnt_clear !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_quiet[%0d]: got clear=%b valid=%b expected 0 0", c, cnt_clear, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_run_gating();
        test_dump();
        test_backpressure();
        test_clear_stalled();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
